// File: rtl/k_16_sqrt.sv
`timescale 1ns / 1ps
// Approximate FP16 square root: 32-segment piecewise-constant mantissa ROM
// behind a two-stage valid/ready pipeline with a single global enable.
module k_16_sqrt #(
  parameter logic [15:0] NAN_CODE = 16'h7E00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        invalid
);

  typedef enum logic [2:0] {
    CL_NORM, CL_ZERO, CL_SUB, CL_INF, CL_NAN, CL_NEG
  } cls_e;

  logic       en;
  logic       sign_f;
  logic [4:0] exp_f;
  logic [9:0] man_f;
  logic [5:0] exp_sum;
  cls_e       cls_c;

  // Whole pipe stalls as one unit; bubbles are held, not collapsed.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign sign_f  = in[15];
  assign exp_f   = in[14:10];
  assign man_f   = in[9:0];
  assign exp_sum = {1'b0, exp_f} + 6'd15;

  always_comb begin
    cls_c = CL_NORM;
    if (exp_f == 5'd31 && man_f != '0)       cls_c = CL_NAN;
    else if (sign_f && {exp_f, man_f} != '0) cls_c = CL_NEG;
    else if (exp_f == '0)                    cls_c = (man_f == '0) ? CL_ZERO : CL_SUB;
    else if (exp_f == 5'd31)                 cls_c = CL_INF;
  end

  logic       s1_valid;
  cls_e       s1_cls;
  logic       s1_sign;
  logic       s1_p;
  logic [3:0] s1_k;
  logic [4:0] s1_exp;

  // NOTE: state is written with <= so every register samples pre-edge values;
  // the async reset clears data as well as valids so out/invalid read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cls   <= CL_NORM;
      s1_sign  <= 1'b0;
      s1_p     <= 1'b0;
      s1_k     <= '0;
      s1_exp   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_cls   <= cls_c;
      s1_sign  <= sign_f;
      s1_p     <= ~exp_f[0];
      s1_k     <= man_f[9:6];
      s1_exp   <= exp_sum[5:1];
    end
  end

  // Segment midpoints: p selects sqrt of [1,2) (p=0) or [2,4) (p=1).
  logic [9:0] rt;
  always_comb begin
    rt = '0;
    case ({s1_p, s1_k})
      5'd0:  rt = 10'd16;
      5'd1:  rt = 10'd47;
      5'd2:  rt = 10'd77;
      5'd3:  rt = 10'd106;
      5'd4:  rt = 10'd135;
      5'd5:  rt = 10'd163;
      5'd6:  rt = 10'd190;
      5'd7:  rt = 10'd217;
      5'd8:  rt = 10'd243;
      5'd9:  rt = 10'd269;
      5'd10: rt = 10'd294;
      5'd11: rt = 10'd318;
      5'd12: rt = 10'd343;
      5'd13: rt = 10'd366;
      5'd14: rt = 10'd390;
      5'd15: rt = 10'd413;
      5'd16: rt = 10'd447;
      5'd17: rt = 10'd491;
      5'd18: rt = 10'd533;
      5'd19: rt = 10'd575;
      5'd20: rt = 10'd615;
      5'd21: rt = 10'd655;
      5'd22: rt = 10'd693;
      5'd23: rt = 10'd731;
      5'd24: rt = 10'd768;
      5'd25: rt = 10'd804;
      5'd26: rt = 10'd840;
      5'd27: rt = 10'd875;
      5'd28: rt = 10'd909;
      5'd29: rt = 10'd942;
      5'd30: rt = 10'd975;
      5'd31: rt = 10'd1008;
      default: rt = '0;
    endcase
  end

  logic [15:0] res_c;
  logic        inv_c;

  always_comb begin
    res_c = {1'b0, s1_exp, rt};
    inv_c = 1'b0;
    case (s1_cls)
      CL_NAN, CL_NEG: begin
        res_c = NAN_CODE;
        inv_c = 1'b1;
      end
      CL_ZERO: res_c = {s1_sign, 15'd0};
      CL_SUB:  res_c = '0;
      CL_INF:  res_c = 16'h7C00;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      invalid   <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      out       <= res_c;
      invalid   <= inv_c;
    end
  end

endmodule
